// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter sharing one split OR-approximate adder among NREQ requesters.
// Optional saturating approximation-error counter enabled by defining APPROX_ERR_STAT_EN.
module approx_add_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 32,
  parameter int LSB_APPROX = 16,
  parameter int IDW        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_exact,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH:0]        rsp_sum,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_exact,
  output logic                  busy,
  output logic [15:0]           err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             exact_q, exact_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   approx_res, exact_res;

  // Low bits are OR-ed; the top approximated bit pair generates the carry into the exact part.
  function automatic logic [WIDTH:0] approx_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    logic           cin;
    s   = '0;
    cin = a[LSB_APPROX-1] & b[LSB_APPROX-1];
    s[LSB_APPROX-1:0] = a[LSB_APPROX-1:0] | b[LSB_APPROX-1:0];
    s[WIDTH:LSB_APPROX] = {1'b0, a[WIDTH-1:LSB_APPROX]} + {1'b0, b[WIDTH-1:LSB_APPROX]}
                        + {{(WIDTH-LSB_APPROX){1'b0}}, cin};
    return s;
  endfunction

  assign approx_res = approx_sum(a_q, b_q);
  assign exact_res  = {1'b0, a_q} + {1'b0, b_q};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int p = 0; p < NREQ; p++) begin
      if (rr_ptr_q == IDW'(p)) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!grant_found && req_valid[(p + k) % NREQ]) begin
            grant_found = 1'b1;
            grant_id    = IDW'((p + k) % NREQ);
          end
        end
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == IDW'(k)) begin
        a_sel = req_a[k*WIDTH +: WIDTH];
        b_sel = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Reset also forces ready low so every output reads zero while rst_n is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == S_IDLE) && grant_found) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    exact_d  = exact_q;
    sum_d    = sum_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          a_d     = a_sel;
          b_d     = b_sel;
          exact_d = req_exact[grant_id];
          id_d    = grant_id;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        sum_d   = approx_res;
        state_d = exact_q ? S_FIX : S_DONE;
      end
      S_FIX: begin
        sum_d   = exact_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d  = S_IDLE;
          rr_ptr_d = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      exact_q  <= 1'b0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      exact_q  <= exact_d;
      sum_q    <= sum_d;
    end
  end

  assign rsp_valid = (state_q == S_DONE);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign rsp_exact = exact_q;
  assign busy      = (state_q != S_IDLE);

`ifdef APPROX_ERR_STAT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == S_CALC) && !exact_q && (approx_res != exact_res) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Self-checking bench for approx_add_arbiter: directed spec cases plus randomized traffic
// checked against an arithmetic reference model of arbitration, latency and sums.
module tb_approx_add_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int L    = 16;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_exact;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_exact;
  logic              busy;
  logic [15:0]       err_cnt;

  int          checks;
  int          errors;
  int          rr_model;
  logic [15:0] err_exp;

  approx_add_arbiter #(.NREQ(NREQ), .WIDTH(W), .LSB_APPROX(L), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_exact(req_exact),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id), .rsp_exact(rsp_exact),
    .busy(busy), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the split-adder definition.
  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic ex);
    longint unsigned aa, bb, low, up, cin;
    aa = a;
    bb = b;
    if (ex) return (W+1)'(aa + bb);
    low = (aa | bb) & ((64'd1 << L) - 1);
    cin = ((aa & bb) >> (L - 1)) & 64'd1;
    up  = (aa >> L) + (bb >> L) + cin;
    return (W+1)'((up << L) | low);
  endfunction

  function automatic logic [W:0] model_exact(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned aa, bb;
    aa = a;
    bb = b;
    return (W+1)'(aa + bb);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    rr_model = 0;
    err_exp  = '0;
  endtask

  // One full transaction from the IDLE negedge through the handshake; low_cycles >= 1 DONE cycles with rsp_ready=0.
  task automatic do_txn(input logic [NREQ-1:0] mask, input logic [NREQ*W-1:0] av, input logic [NREQ*W-1:0] bv,
                        input logic [NREQ-1:0] exv, input int low_cycles,
                        output int obs_id, output logic [W:0] obs_sum);
    int             g;
    int             idx;
    logic [NREQ-1:0] exp_ready;
    logic [W-1:0]   ga, gb;
    logic           gex;
    logic [W:0]     exp_sum;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (rr_model + k) % NREQ;
      if (g < 0 && mask[idx]) g = idx;
    end
    ga  = av[g*W +: W];
    gb  = bv[g*W +: W];
    gex = exv[g];
    exp_sum   = model_sum(ga, gb, gex);
    exp_ready = '0;
    exp_ready[g] = 1'b1;

    req_valid = mask;
    req_a     = av;
    req_b     = bv;
    req_exact = exv;
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== exp_ready) begin
      errors++;
      $display("FAIL grant_ready: got %b expected %b", req_ready, exp_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
    req_exact = 4'($urandom);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL calc_cycle: got valid=%b busy=%b ready=%b expected 0 1 0000", rsp_valid, busy, req_ready);
    end
    if (gex) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL fix_cycle_valid: got %b expected 0", rsp_valid);
      end
    end
`ifdef APPROX_ERR_STAT_EN
    if (!gex && (model_sum(ga, gb, 1'b0) !== model_exact(ga, gb)) && err_exp != 16'hFFFF) err_exp = err_exp + 16'd1;
`endif
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    obs_id  = int'(rsp_id);
    obs_sum = rsp_sum;
    for (int s = 0; s < low_cycles; s++) begin
      if (s > 0) begin
        @(negedge clk);
        #1;
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== exp_sum || int'(rsp_id) !== g || rsp_exact !== gex) begin
        errors++;
        $display("FAIL response: got v=%b sum=%h id=%0d ex=%b expected 1 %h %0d %b",
                 rsp_valid, rsp_sum, rsp_id, rsp_exact, exp_sum, g, gex);
      end
      checks++;
      if (req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL done_no_accept: got ready=%b busy=%b expected 0000 1", req_ready, busy);
      end
    end
    checks++;
    if (err_cnt !== err_exp) begin
      errors++;
      $display("FAIL err_cnt: got %h expected %h", err_cnt, err_exp);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake_idle: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
    rr_model = (g + 1) % NREQ;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || rsp_sum !== '0 ||
        rsp_id !== '0 || rsp_exact !== 1'b0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b busy=%b rdy=%b sum=%h id=%0d ex=%b err=%h expected all zero",
               rsp_valid, busy, req_ready, rsp_sum, rsp_id, rsp_exact, err_cnt);
    end
    rst_n = 1'b1;
    rr_model = 0;
    err_exp  = '0;
  endtask

  task automatic test_approx();
    int id;
    logic [W:0] s;
    do_txn(4'b0001, {96'h0, 32'h0000_8001}, {96'h0, 32'h0000_8001}, 4'b0000, 1, id, s);
    checks++;
    if (s !== 33'h0_0001_8001 || id !== 0) begin
      errors++;
      $display("FAIL approx_8001: got sum=%h id=%0d expected 000018001 0", s, id);
    end
  endtask

  task automatic test_exact();
    int id;
    logic [W:0] s;
    do_txn(4'b0001, {96'h0, 32'h0000_8001}, {96'h0, 32'h0000_8001}, 4'b0001, 1, id, s);
    checks++;
    if (s !== 33'h0_0001_0002) begin
      errors++;
      $display("FAIL exact_8001: got %h expected 000010002", s);
    end
    do_txn(4'b0010, {64'h0, 32'hFFFF_FFFF, 32'h0}, {64'h0, 32'hFFFF_FFFF, 32'h0}, 4'b0010, 1, id, s);
    checks++;
    if (s !== 33'h1_FFFF_FFFE || id !== 1) begin
      errors++;
      $display("FAIL exact_all_ones: got %h id=%0d expected 1fffffffe 1", s, id);
    end
  endtask

  task automatic test_boundary();
    int id;
    logic [W:0] s;
    // Upper-part overflow in approximate mode must reach the carry-out bit.
    do_txn(4'b0100, {32'h0, 32'hFFFF_0000, 64'h0}, {32'h0, 32'hFFFF_0000, 64'h0}, 4'b0000, 1, id, s);
    checks++;
    if (s !== 33'h1_FFFE_0000 || id !== 2) begin
      errors++;
      $display("FAIL approx_overflow: got %h id=%0d expected 1fffe0000 2", s, id);
    end
    do_txn(4'b1000, {32'h1234_5678, 96'h0}, {32'h1111_1111, 96'h0}, 4'b0000, 1, id, s);
    do_txn(4'b1001, {32'h0, 64'h0, 32'h0000_0001}, {32'h0, 64'h0, 32'h0000_0002}, 4'b0000, 1, id, s);
    checks++;
    if (id !== 0 || s !== 33'h0_0000_0003) begin
      errors++;
      $display("FAIL rr_wrap: got id=%0d sum=%h expected 0 000000003", id, s);
    end
  endtask

  task automatic test_round_robin();
    int id;
    logic [W:0] s;
    int exp_ids[4];
    exp_ids = '{0, 2, 0, 2};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_txn(4'b0101, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             4'($urandom), 1, id, s);
      checks++;
      if (id !== exp_ids[i]) begin
        errors++;
        $display("FAIL rr_sequence[%0d]: got %0d expected %0d", i, id, exp_ids[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int id;
    logic [W:0] s;
    do_txn(4'b0010, {64'h0, 32'hA5A5_0F0F, 32'h0}, {64'h0, 32'h0101_F0F0, 32'h0}, 4'b0000, 5, id, s);
    do_txn(4'b0100, {32'h0, 32'h7FFF_FFFF, 64'h0}, {32'h0, 32'h0000_0001, 64'h0}, 4'b0100, 5, id, s);
    checks++;
    if (s !== 33'h0_8000_0000) begin
      errors++;
      $display("FAIL backpressure_exact: got %h expected 080000000", s);
    end
  endtask

  task automatic test_reset_mid_calc();
    int id;
    logic [W:0] s;
    do_txn(4'b0001, {96'h0, 32'h5}, {96'h0, 32'h6}, 4'b0000, 1, id, s);
    @(negedge clk);
    req_valid = 4'b0010;
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
    req_exact = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'hF;
    rst_n     = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_mid_calc: got v=%b busy=%b rdy=%b expected 0 0 0000", rsp_valid, busy, req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_sum !== '0 || rsp_id !== '0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_regs: got sum=%h id=%0d err=%h expected 0 0 0", rsp_sum, rsp_id, err_cnt);
    end
    req_valid = '0;
    rst_n     = 1'b1;
    rr_model  = 0;
    err_exp   = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dropped_request: got v=%b busy=%b expected 0 0", rsp_valid, busy);
    end
    do_txn(4'b1111, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           4'b0000, 1, id, s);
    checks++;
    if (id !== 0) begin
      errors++;
      $display("FAIL post_reset_grant: got %0d expected 0", id);
    end
  endtask

  task automatic test_err_stat();
`ifdef APPROX_ERR_STAT_EN
    int id;
    logic [W:0] s;
    apply_reset();
    do_txn(4'b0001, {96'h0, 32'h0000_8001}, {96'h0, 32'h0000_8001}, 4'b0000, 1, id, s);
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL err_first_mismatch: got %h expected 0001", err_cnt);
    end
    do_txn(4'b0010, {64'h0, 32'h1, 32'h0}, {64'h0, 32'h2, 32'h0}, 4'b0000, 1, id, s);
    do_txn(4'b0100, {32'h0, 32'h0000_8001, 64'h0}, {32'h0, 32'h0000_8001, 64'h0}, 4'b0100, 1, id, s);
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL err_unchanged: got %h expected 0001", err_cnt);
    end
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.err_cnt_q;
    err_exp = 16'hFFFF;
    do_txn(4'b1000, {32'h0000_8001, 96'h0}, {32'h0000_8001, 96'h0}, 4'b0000, 1, id, s);
    checks++;
    if (err_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL err_saturate: got %h expected ffff", err_cnt);
    end
`endif
  endtask

  task automatic test_random();
    int id;
    logic [W:0] s;
    logic [NREQ-1:0] mask;
    for (int i = 0; i < 40; i++) begin
      mask = NREQ'($urandom_range(1, 15));
      do_txn(mask, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             4'($urandom), $urandom_range(1, 3), id, s);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rr_model  = 0;
    err_exp   = '0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_exact = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_approx();
    test_exact();
    test_boundary();
    test_round_robin();
    test_backpressure();
    test_reset_mid_calc();
    test_err_stat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
